// File: rtl/f_pc_unit.sv
// ---------------------------------------------------------------------------
// f_pc_unit -- fetch-stage program counter of the pipelined MIPS core.
//
// Holds PC_F and picks the next fetch address each edge. Priority, highest
// first: reset, exception/interrupt entry, stall (hold), ERET return to EPC,
// then the D-stage redirect (branch / j / jr), then sequential PC+4.
// Arithmetic wraps modulo 2^32. No alignment or range checking is done here;
// the downstream F-stage checker raises AdEL on a bad address.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   stall       in   hazard-unit stall; freezes PC (exception still loads)
//   exc_req     in   CP0 exception/interrupt request (M stage)
//   eret_d      in   ERET decoded in D stage
//   epc         in   CP0 EPC value
//   npc_op      in   D redirect: 00 seq, 01 branch, 10 j/jal, 11 jr/jalr
//   b_target    in   branch target
//   j_target    in   jump target
//   jr_target   in   forwarded rs value
//   pc_f        out  current fetch PC (registered)
//   pc_plus8_f  out  pc_f + 8, link value source
//   eret_aft    out  F holds the wrong-path fetch behind ERET
//   flush_fd    out  clear F/D register on this edge
//   redirect_q  out  cause of last PC load: 00 seq/branch, 01 ERET,
//                    10 exception, 11 reset
// ---------------------------------------------------------------------------
module f_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_d,
  input  logic [31:0] epc,
  input  logic [1:0]  npc_op,
  input  logic [31:0] b_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus8_f,
  output logic        eret_aft,
  output logic        flush_fd,
  output logic [1:0]  redirect_q
);

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    RDR_SEQ   = 2'b00,
    RDR_ERET  = 2'b01,
    RDR_EXC   = 2'b10,
    RDR_RESET = 2'b11
  } redirect_e;

  logic [31:0] next_pc;
  redirect_e   next_redirect;

  // Branch and jump redirects land after the delay-slot instruction already
  // in F, so they never flush. ERET has no delay slot: the instruction
  // fetched behind it is killed, unless an exception takes over the edge
  // (the pipeline-wide flush logic owns that case).
  assign eret_aft   = eret_d & ~exc_req;
  assign flush_fd   = eret_d & ~stall & ~exc_req;
  assign pc_plus8_f = pc_f + 32'd8;

  always_comb begin
    // NOTE: defaults are assigned before any branch so every path drives
    // both outputs; a missing default would infer a latch.
    next_pc       = pc_f + 32'd4;
    next_redirect = RDR_SEQ;
    if (exc_req) begin
      // An exception overrides stall: the handler entry must not be lost.
      next_pc       = HANDLER_PC;
      next_redirect = RDR_EXC;
    end else if (stall) begin
      next_pc       = pc_f;
      next_redirect = redirect_e'(redirect_q);
    end else if (eret_d) begin
      // ERET beats a concurrent D redirect even though a legal decoder never
      // issues both.
      next_pc       = epc;
      next_redirect = RDR_ERET;
    end else begin
      unique case (npc_op_e'(npc_op))
        NPC_BRANCH: next_pc = b_target;
        NPC_JUMP:   next_pc = j_target;
        NPC_JR:     next_pc = jr_target;
        default:    next_pc = pc_f + 32'd4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      pc_f       <= RESET_PC;
      redirect_q <= RDR_RESET;
    end else begin
      pc_f       <= next_pc;
      redirect_q <= next_redirect;
    end
  end

endmodule
